// File: rtl/counter_datachk.sv
// counter_datachk: receive-side checker for the incrementing-counter loopback
// pattern. Recovers word alignment by rotating a 16-bit window of the current
// and previous raw words, verifies that each aligned word is the previous one
// plus one (mod 256), and reports lock, per-error strobes and saturating
// error/word statistics. Single clock domain, synchronous active-low reset.
module counter_datachk #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int SLIP_EN  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic        clear,
    output logic        locked,
    output logic [2:0]  slip,
    output logic [7:0]  data_aligned,
    output logic        aligned_valid,
    output logic        err_pulse,
    output logic [15:0] err_cnt,
    output logic [31:0] word_cnt
);

    // Lock state encoding.
    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Priming stages: nothing seen yet, next word loads the reference, comparing.
    localparam logic [1:0] PRIME_EMPTY = 2'd0;
    localparam logic [1:0] PRIME_REF   = 2'd1;
    localparam logic [1:0] PRIME_RUN   = 2'd2;

    localparam logic [7:0]  LOCK_THR  = 8'(LOCK_CNT);
    localparam logic [3:0]  LOSS_THR  = 4'(LOSS_CNT);
    localparam logic [15:0] ERR_MAX   = 16'hFFFF;
    localparam logic [31:0] WORD_MAX  = 32'hFFFF_FFFF;

    logic [0:0]  state_q,  state_d;
    logic [2:0]  slip_q,   slip_d;
    logic [7:0]  prev_q,   prev_d;
    logic [7:0]  ref_q,    ref_d;
    logic [7:0]  match_q,  match_d;
    logic [3:0]  miss_q,   miss_d;
    logic [1:0]  prime_q,  prime_d;
    logic [7:0]  da_q,     da_d;
    logic        av_q,     av_d;
    logic        ep_q,     ep_d;
    logic [15:0] ec_q,     ec_d;
    logic [31:0] wc_q,     wc_d;

    logic [15:0] window_s;
    logic [7:0]  aligned_s;
    logic [7:0]  expected_s;
    logic        match_s;
    logic        inc_err_s;
    logic        inc_word_s;

    // Rotate the two-word window by the current slip and form the expected word.
    always_comb begin
        window_s   = {data_in, prev_q};
        aligned_s  = window_s[slip_q +: 8];
        expected_s = ref_q + 8'd1;
        match_s    = (aligned_s == expected_s);
    end

    // Next-state logic: priming, search/lock FSM and statistics counters.
    always_comb begin
        state_d    = state_q;
        slip_d     = slip_q;
        prev_d     = prev_q;
        ref_d      = ref_q;
        match_d    = match_q;
        miss_d     = miss_q;
        prime_d    = prime_q;
        da_d       = da_q;
        av_d       = 1'b0;
        ep_d       = 1'b0;
        ec_d       = ec_q;
        wc_d       = wc_q;
        inc_err_s  = 1'b0;
        inc_word_s = 1'b0;

        if (data_valid) begin
            prev_d = data_in;
            case (prime_q)
                PRIME_EMPTY: begin
                    prime_d = PRIME_REF;
                end
                PRIME_REF: begin
                    ref_d   = aligned_s;
                    da_d    = aligned_s;
                    av_d    = 1'b1;
                    prime_d = PRIME_RUN;
                end
                PRIME_RUN: begin
                    ref_d = aligned_s;
                    da_d  = aligned_s;
                    av_d  = 1'b1;
                    case (state_q)
                        ST_SEARCH: begin
                            if (match_s) begin
                                if ((match_q + 8'd1) == LOCK_THR) begin
                                    state_d = ST_LOCKED;
                                    match_d = 8'd0;
                                    miss_d  = 4'd0;
                                end else begin
                                    match_d = match_q + 8'd1;
                                end
                            end else begin
                                match_d = 8'd0;
                                prime_d = PRIME_REF;
                                if (SLIP_EN != 0) begin
                                    slip_d = slip_q + 3'd1;
                                end else begin
                                    slip_d = 3'd0;
                                end
                            end
                        end
                        ST_LOCKED: begin
                            inc_word_s = 1'b1;
                            if (match_s) begin
                                miss_d = 4'd0;
                            end else begin
                                ep_d      = 1'b1;
                                inc_err_s = 1'b1;
                                if ((miss_q + 4'd1) == LOSS_THR) begin
                                    state_d = ST_SEARCH;
                                    miss_d  = 4'd0;
                                    match_d = 8'd0;
                                    prime_d = PRIME_REF;
                                end else begin
                                    miss_d = miss_q + 4'd1;
                                end
                            end
                        end
                        default: begin
                            state_d = ST_SEARCH;
                        end
                    endcase
                end
                default: begin
                    prime_d = PRIME_EMPTY;
                end
            endcase
        end else begin
            prev_d = prev_q;
        end

        // Saturating statistics; clear overrides any coincident increment.
        if (clear) begin
            ec_d = 16'd0;
            wc_d = 32'd0;
        end else begin
            if (inc_err_s && (ec_q != ERR_MAX)) begin
                ec_d = ec_q + 16'd1;
            end else begin
                ec_d = ec_q;
            end
            if (inc_word_s && (wc_q != WORD_MAX)) begin
                wc_d = wc_q + 32'd1;
            end else begin
                wc_d = wc_q;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_SEARCH;
            slip_q  <= 3'd0;
            prev_q  <= 8'd0;
            ref_q   <= 8'd0;
            match_q <= 8'd0;
            miss_q  <= 4'd0;
            prime_q <= PRIME_EMPTY;
            da_q    <= 8'd0;
            av_q    <= 1'b0;
            ep_q    <= 1'b0;
            ec_q    <= 16'd0;
            wc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            slip_q  <= slip_d;
            prev_q  <= prev_d;
            ref_q   <= ref_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            prime_q <= prime_d;
            da_q    <= da_d;
            av_q    <= av_d;
            ep_q    <= ep_d;
            ec_q    <= ec_d;
            wc_q    <= wc_d;
        end
    end

    assign locked        = (state_q == ST_LOCKED);
    assign slip          = slip_q;
    assign data_aligned  = da_q;
    assign aligned_valid = av_q;
    assign err_pulse     = ep_q;
    assign err_cnt       = ec_q;
    assign word_cnt      = wc_q;

endmodule

// File: tb/tb_counter_datachk.sv
// Directed testbench for counter_datachk: a vector table for lock, error and
// clear behaviour, plus sequences for lock loss, reset, valid gaps, bit-slip
// search and error-counter saturation (on a second instance).
module tb_counter_datachk;

    logic        clk = 1'b0;
    logic        rst, dv, clr;
    logic [7:0]  din;
    logic        locked, av, ep;
    logic [2:0]  slip;
    logic [7:0]  da;
    logic [15:0] ec;
    logic [31:0] wc;

    logic        s_rst, s_dv, s_clr;
    logic [7:0]  s_din;
    logic        s_locked, s_av, s_ep;
    logic [2:0]  s_slip;
    logic [7:0]  s_da;
    logic [15:0] s_ec;
    logic [31:0] s_wc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_datachk dut (
        .clk(clk), .rst(rst), .data_in(din), .data_valid(dv), .clear(clr),
        .locked(locked), .slip(slip), .data_aligned(da), .aligned_valid(av),
        .err_pulse(ep), .err_cnt(ec), .word_cnt(wc)
    );

    counter_datachk #(.LOCK_CNT(2), .LOSS_CNT(15), .SLIP_EN(1)) dut_sat (
        .clk(clk), .rst(s_rst), .data_in(s_din), .data_valid(s_dv), .clear(s_clr),
        .locked(s_locked), .slip(s_slip), .data_aligned(s_da), .aligned_valid(s_av),
        .err_pulse(s_ep), .err_cnt(s_ec), .word_cnt(s_wc)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        c;
        logic        e_lk;
        logic        e_av;
        logic [7:0]  e_da;
        logic        e_ep;
        logic [15:0] e_ec;
        logic [31:0] e_wc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic v, input logic [7:0] d, input logic c,
                                input logic lk, input logic a, input logic [7:0] dd,
                                input logic e, input logic [15:0] n_e, input logic [31:0] n_w);
        vec_t r;
        r.v = v; r.d = d; r.c = c; r.e_lk = lk; r.e_av = a; r.e_da = dd;
        r.e_ep = e; r.e_ec = n_e; r.e_wc = n_w;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic c);
        dv = v; din = d; clr = c;
        @(posedge clk); #1;
    endtask

    task automatic s_step(input logic v, input logic [7:0] d);
        s_dv = v; s_din = d;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0; dv = 1'b0; clr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        int          lock_at;
        int          vcount;
        int          k;
        logic [7:0]  c0, c1, last_da;
        logic        mono_ok;
        logic [2:0]  prev_slip;

        rst = 1'b0; dv = 1'b0; clr = 1'b0; din = 8'h00;
        s_rst = 1'b0; s_dv = 1'b0; s_clr = 1'b0; s_din = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_outputs", {locked, slip, av, da, ep, ec, wc}, 62'd0);
        rst = 1'b1; s_rst = 1'b1;

        // Aligned counter stream; at slip 0 the aligned word is the previous raw word.
        for (int i = 0; i < 20; i++)
            add(1'b1, 8'(i), 1'b0, (i >= 17), (i >= 1), (i >= 1) ? 8'(i - 1) : 8'h00,
                1'b0, 16'd0, (i >= 18) ? 32'(i - 17) : 32'd0);
        add(1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 8'd18,  1'b0, 16'd0, 32'd2);  // gap: no change
        add(1'b1, 8'd20, 1'b0, 1'b1, 1'b1, 8'd19,  1'b0, 16'd0, 32'd3);
        add(1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'd20,  1'b0, 16'd0, 32'd4);  // replaces 21
        add(1'b1, 8'h5B, 1'b0, 1'b1, 1'b1, 8'h5A,  1'b1, 16'd1, 32'd5);  // 0x5A vs 21
        add(1'b1, 8'h5C, 1'b0, 1'b1, 1'b1, 8'h5B,  1'b0, 16'd1, 32'd6);  // next matches
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5B,  1'b0, 16'd0, 32'd0);  // idle clear
        add(1'b1, 8'h5D, 1'b1, 1'b1, 1'b1, 8'h5C,  1'b0, 16'd0, 32'd0);  // clear beats inc
        add(1'b1, 8'h5E, 1'b0, 1'b1, 1'b1, 8'h5D,  1'b0, 16'd0, 32'd1);
        add(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5E,  1'b0, 16'd0, 32'd2);
        add(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h00,  1'b1, 16'd0, 32'd0);  // clear during error
        add(1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01,  1'b0, 16'd0, 32'd1);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c);
            chk($sformatf("vec%0d", i), {locked, slip, av, da, ep, ec, wc},
                {tbl[i].e_lk, 3'd0, tbl[i].e_av, tbl[i].e_da, tbl[i].e_ep, tbl[i].e_ec, tbl[i].e_wc});
        end

        // Lock loss: first zero still matches (aligned=0x02), then four bad aligned words.
        for (int i = 0; i < 4; i++) step(1'b1, 8'h00, 1'b0);
        chk("loss_locked_after_3_bad", {31'd0, locked}, 32'd1);
        step(1'b1, 8'h00, 1'b0);
        chk("loss_unlocked_after_4_bad", {31'd0, locked}, 32'd0);
        chk("loss_err_pulse", {31'd0, ep}, 32'd1);
        chk("loss_err_cnt", {16'd0, ec}, 32'd4);
        chk("loss_slip_kept", {29'd0, slip}, 32'd0);

        // Re-lock on a stream continuing from the last bad word.
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
        chk("relock_not_yet_16", {31'd0, locked}, 32'd0);
        step(1'b1, 8'd17, 1'b0);
        step(1'b1, 8'd18, 1'b0);
        chk("relock_after_18", {31'd0, locked}, 32'd1);
        chk("relock_slip", {29'd0, slip}, 32'd0);

        // One-cycle reset while locked with errors recorded.
        rst = 1'b0; dv = 1'b1; din = 8'd19; clr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; dv = 1'b0;
        chk("reset_mid_lock", {locked, slip, av, da, ep, ec, wc}, 62'd0);

        // Aligned stream with ~30% valid duty: lock counts valid words only.
        lock_at = 0; vcount = 0;
        for (int cyc = 0; cyc < 3000 && vcount < 40; cyc++) begin
            if ($urandom_range(0, 9) < 3) begin
                step(1'b1, 8'(8'h80 + vcount), 1'b0);
                vcount++;
            end else begin
                step(1'b0, 8'hA5, 1'b0);
            end
            if (locked && lock_at == 0) lock_at = vcount;
        end
        chk("gap_lock_word", 32'(lock_at), 32'd18);
        chk("gap_err_cnt", {16'd0, ec}, 32'd0);
        chk("gap_word_cnt", wc, 32'(vcount - 18));

        // Stream whose true word sits at window[10:3]: slip searches 0->3.
        pulse_reset();
        mono_ok = 1'b1; prev_slip = 3'd0; k = 16;
        for (int w = 0; w < 300 && !locked; w++) begin
            c0 = 8'(k); c1 = 8'(k + 1);
            step(1'b1, {c1[4:0], c0[7:5]}, 1'b0);
            if (slip < prev_slip) mono_ok = 1'b0;
            prev_slip = slip;
            k++;
        end
        chk("rot_locked", {31'd0, locked}, 32'd1);
        chk("rot_slip", {29'd0, slip}, 32'd3);
        chk("rot_slip_monotonic", {31'd0, mono_ok}, 32'd1);
        last_da = da;
        for (int w = 0; w < 5; w++) begin
            c0 = 8'(k); c1 = 8'(k + 1);
            step(1'b1, {c1[4:0], c0[7:5]}, 1'b0);
            chk($sformatf("rot_incr%0d", w), {av, da}, {1'b1, 8'(last_da + 8'd1)});
            last_da = da;
            k++;
        end
        chk("rot_err_cnt", {16'd0, ec}, 32'd0);
        dv = 1'b0;

        // Saturation: lock, then 5000 groups of 14 errors + 1 match (LOSS_CNT=15).
        for (int i = 0; i < 4; i++) s_step(1'b1, 8'(i));
        chk("sat_locked", {31'd0, s_locked}, 32'd1);
        for (int g = 0; g < 5000; g++) begin
            for (int i = 0; i < 14; i++) s_step(1'b1, 8'h00);
            s_step(1'b1, 8'h01);
            if (g == 0) chk("sat_first_group", {16'd0, s_ec}, 32'd14);
        end
        s_dv = 1'b0;
        chk("sat_err_cnt", {16'd0, s_ec}, 32'h0000_FFFF);
        chk("sat_word_cnt", s_wc, 32'd75000);
        chk("sat_still_locked", {31'd0, s_locked}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_datachk.md
# counter_datachk

Receive-side pattern checker for the HPIO loopback path; the reader counterpart of `counter_datagen`. Consumes 8-bit parallel words from the RX fabric interface and recovers word alignment by fabric bit-slip. Verifies the incrementing-counter pattern (mod 256) and reports lock, error and word statistics for the lab monitor. Sits in the `clk` fabric domain directly behind the RX FIFO read port.

## Interface
Parameters:
- `LOCK_CNT`, 16: consecutive good compares needed to declare lock (2..255).
- `LOSS_CNT`, 4: consecutive bad compares while locked that drop lock (1..15).
- `SLIP_EN`, 1: 1 = automatic bit-slip search; 0 = `slip` held at 0.

Ports:
- `clk`  input  1  fabric clock, same clock as the RX FIFO read port.
- `rst`  input  1  reset; synchronous, active-low.
- `data_in`  input  8  raw word from RX `data_to_fabric`.
- `data_valid`  input  1  `data_in` qualifier (FIFO read data valid).
- `clear`  input  1  synchronous clear of `err_cnt` and `word_cnt` only.
- `locked`  output  1  pattern lock.
- `slip`  output  3  current bit rotation, 0..7.
- `data_aligned`  output  8  rotated word, registered.
- `aligned_valid`  output  1  one-cycle strobe with `data_aligned`.
- `err_pulse`  output  1  one-cycle strobe per mismatch while locked.
- `err_cnt`  output  16  saturating mismatch count while locked.
- `word_cnt`  output  32  saturating count of words checked while locked.

## Operation
- Each `data_valid` cycle: window = {`data_in`, `prev_word`}; aligned = window[`slip`+7 : `slip`]; then `prev_word` <= `data_in`. Cycles with `data_valid` low change no state.
- Priming: after reset the first valid word only loads `prev_word`. The next valid word (and the first valid word after any `slip` change or lock loss) only loads `ref` <= aligned; no compare.
- Compare: expected = `ref` + 1 (8-bit wrap, 0xFF -> 0x00). `ref` <= aligned on every compared word, whether it matches or not, so one bad word costs one error.
- SEARCH (reset state):
  - Match: `match_cnt` + 1. Reaching `LOCK_CNT` -> LOCKED.
  - Mismatch: `match_cnt` <= 0; `slip` <= `slip` + 1 (7 wraps to 0) when `SLIP_EN`=1; re-prime.
- LOCKED:
  - Match: `miss_cnt` <= 0; `word_cnt` + 1.
  - Mismatch: `err_pulse`; `err_cnt` + 1; `word_cnt` + 1; `miss_cnt` + 1.
  - `miss_cnt` reaching `LOSS_CNT` -> SEARCH: `slip` kept, `match_cnt` <= 0, re-prime.
- `err_cnt` saturates at 0xFFFF; `word_cnt` saturates at 0xFFFFFFFF.
- `clear` coincident with an increment: the counter goes to 0 (clear wins).
- Reset: all outputs 0; state SEARCH; `prev_word`, `ref`, `match_cnt`, `miss_cnt` all 0; priming restarts from the first stage. Reset mid-lock takes effect on the next edge.

## Timing
- All outputs registered. `data_aligned`/`aligned_valid` follow the edge that samples `data_valid`, from the second valid word after reset onward.
- `err_pulse`, counter updates and `locked` changes appear one cycle after the sampled word.
- Correct slip from reset: `locked` rises one cycle after valid word `LOCK_CNT`+2.
- Slip change takes effect for the next valid word. Worst-case lock is under 8*(`LOCK_CNT`+2) valid words.
- `data_valid` gaps of any length are allowed; counts are per valid word, never per cycle.

## Test plan
- Aligned counter 0x00..0xFF and wrap, continuous valid, defaults -> `locked`=1 after 18 valid words; `slip`=0; `err_cnt`=0; `word_cnt` = valid words after lock.
- Stream rotated so the true word is window[10:3] -> `slip` steps 0->1->2->3; `locked` asserts; `data_aligned` increments by 1 per strobe.
- Locked, with one word replaced by 0x5A -> exactly one `err_pulse`; `err_cnt`=1; `locked` stays 1; the next word is a match.
- Locked, then 4 consecutive bad words -> `locked` falls one cycle after the 4th; `err_cnt`=4; `slip` unchanged; re-lock after 18 good words.
- Random `data_valid` gaps (30% duty) on an aligned stream -> same lock word count as continuous; no errors.
- `rst` low for one cycle while locked -> all outputs 0 next cycle. `clear` pulsed during an error -> `err_cnt`=0. Forced 70000 errors -> `err_cnt`=0xFFFF.
